axi_lite_regbank: RTL and testbench
===================================

AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8: AXI byte-address width; the legal range is 4..16 and 0x10+4*NUM_CTRL SHALL fit in it.
REQ-002 The block SHALL have parameter NUM_CTRL, default 4: number of 32-bit read/write control registers, 1..16.
REQ-003 The block SHALL have parameter NUM_IRQ, default 8: number of interrupt source inputs, 1..32.
REQ-004 The block SHALL have parameter ID_VALUE, default 32'h4C4C0001: constant returned by the ID register.
REQ-005 The block SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the AXI4-Lite write address, write data and write response ports:
- S_AXI_AWADDR (input, ADDR_WIDTH), S_AXI_AWVALID (input, 1), S_AXI_AWREADY (output, 1)
- S_AXI_WDATA (input, 32), S_AXI_WSTRB (input, 4), S_AXI_WVALID (input, 1), S_AXI_WREADY (output, 1)
- S_AXI_BRESP (output, 2), S_AXI_BVALID (output, 1), S_AXI_BREADY (input, 1)
REQ-008 The block SHALL have the AXI4-Lite read address and read data ports:
- S_AXI_ARADDR (input, ADDR_WIDTH), S_AXI_ARVALID (input, 1), S_AXI_ARREADY (output, 1)
- S_AXI_RDATA (output, 32), S_AXI_RRESP (output, 2), S_AXI_RVALID (output, 1), S_AXI_RREADY (input, 1)
REQ-009 The block SHALL have port irq_in, input, NUM_IRQ bits: level sources, synchronous to S_AXI_ACLK; each rising edge latches a pending event.
REQ-010 The block SHALL have port ctrl_out, output, 32*NUM_CTRL bits: CTRL[i] drives bits [32i+31:32i].
REQ-011 The block SHALL have port interrupt_request, output, 1 bit: registered OR of PENDING.

Function
REQ-012 Register decode SHALL use address bits [ADDR_WIDTH-1:2], with bits [1:0] ignored, per this map:
- 0x00 ID: read-only, returns ID_VALUE.
- 0x04 STATUS: write-1-to-clear; bits >= NUM_IRQ read 0.
- 0x08 ENABLE: read/write; bits >= NUM_IRQ read 0 and ignore writes.
- 0x0C PENDING: read-only, STATUS & ENABLE.
- 0x10+4i CTRL[i]: read/write, byte-laned by WSTRB.
REQ-013 Write handshake SHALL follow this sequence:
- In state W_IDLE, when AWVALID and WVALID are both high, AWREADY and WREADY SHALL pulse high together for exactly one cycle, and the write SHALL take effect on that edge.
- The block SHALL then move to W_RESP, with BVALID high from the next cycle.
- BVALID SHALL be held, with BRESP stable, until BREADY; the block SHALL then return to W_IDLE.
- If AWVALID or WVALID arrives alone, AWREADY and WREADY SHALL stay low until both are present.
REQ-014 Read handshake SHALL follow this sequence:
- In state R_IDLE, ARVALID SHALL cause a one-cycle ARREADY pulse, and the address SHALL be sampled on that edge.
- The block SHALL then move to R_DATA, with RVALID, RDATA and RRESP registered and valid on the next cycle.
- These outputs SHALL be held stable until RREADY; the block SHALL then return to R_IDLE.
REQ-015 Each channel SHALL accept at most one outstanding transaction; read and write channels SHALL operate independently and concurrently.
REQ-016 Responses SHALL be OKAY (2'b00) for mapped addresses. Unmapped addresses and writes to ID or PENDING SHALL return SLVERR (2'b10) with no state change. Unmapped reads SHALL return RDATA=0.
REQ-017 CTRL writes SHALL update byte k only where WSTRB[k]=1. STATUS and ENABLE writes SHALL also honour WSTRB per byte.
REQ-018 STATUS[n] SHALL set on the cycle after irq_in[n] goes 0->1. This SHALL use a registered copy of irq_in, whose reset value is 0.
REQ-019 When a STATUS set and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-020 STATUS SHALL latch events independently of ENABLE.
REQ-021 interrupt_request SHALL equal the previous cycle's |(STATUS & ENABLE), giving one-cycle registered latency.
REQ-022 A read of STATUS or PENDING SHALL return the value as of the ARREADY edge.

Reset
REQ-023 When S_AXI_ARESETN is low, the following SHALL be 0 immediately (asynchronously): AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, STATUS, ENABLE, every CTRL (so ctrl_out=0), the irq_in history register and interrupt_request. Both FSMs SHALL go to their IDLE states.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction; no response SHALL be issued after deassertion.
REQ-025 The block SHALL accept the first transaction no earlier than the first rising edge after S_AXI_ARESETN deasserts.

Verification
REQ-026 CTRL write: write 0x10 with data 0xDEADBEEF and WSTRB=4'b0101 -> BRESP=00, and ctrl_out[31:0]=0x00AD00EF on the cycle after the WREADY handshake.
REQ-027 Interrupt path: ENABLE=0x01, pulse irq_in[0] -> STATUS=0x1 after 1 cycle and interrupt_request=1 after 2 cycles. Then write 0x01 to 0x04 -> interrupt_request=0 two cycles after the WREADY handshake.
REQ-028 Set/clear collision: irq_in[3] rising edge in the same cycle as a W1C of bit 3 -> STATUS[3] remains 1.
REQ-029 Error responses:
- Read 0x00 -> RDATA=0x4C4C0001, RRESP=00.
- Read 0x10+4*NUM_CTRL -> RDATA=0, RRESP=10.
- Write 0x0C -> BRESP=10 and PENDING unchanged.
REQ-030 Back-pressure: hold BREADY=0 and RREADY=0 for 5 cycles while a read and a write are concurrent -> BVALID, RVALID and their payloads stay stable, and no second AWREADY or ARREADY pulse occurs.
REQ-031 Reset during R_DATA with RVALID=1 -> RVALID=0 immediately, and ctrl_out=0.

Source files
------------

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for the register bank: slave side faces the bank,
// master side faces whatever drives the bus.
interface axi_lite_regbank_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: ID, W1C interrupt STATUS, ENABLE, PENDING and
// NUM_CTRL byte-laned control registers, with a registered interrupt output.
module axi_lite_regbank #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_CTRL   = 4,
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] ID_VALUE   = 32'h4C4C0001
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  axi_lite_regbank_if.slave       s_axi,
  input  logic [NUM_IRQ-1:0]      irq_in,
  output logic [32*NUM_CTRL-1:0]  ctrl_out,
  output logic                    interrupt_request
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{strb[k]}};
    return m;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (old_v & ~m) | (new_v & m);
  endfunction

  function automatic logic [31:0] irq_ext(input logic [NUM_IRQ-1:0] v);
    return 32'(v);
  endfunction

  w_state_t w_state;
  r_state_t r_state;

  logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic [NUM_IRQ-1:0] status_q, enable_q, irq_d;
  logic [31:0]        ctrl_q [NUM_CTRL];

  logic [31:0] w_idx, r_idx;
  logic        wr_fire, rd_fire;
  logic        w_is_ctrl, w_err, wr_status, wr_enable;
  logic [31:0] status_clr32, enable_wr32;
  logic [NUM_IRQ-1:0] status_nxt;
  logic [31:0] r_data;
  logic        r_err;
  logic        unused_bits;

  assign w_idx   = 32'(s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2]);
  assign r_idx   = 32'(s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2]);
  assign wr_fire = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire = arready_q & s_axi.S_AXI_ARVALID;

  assign w_is_ctrl = (w_idx >= 32'd4) && (w_idx < 32'(4 + NUM_CTRL));
  assign w_err     = !((w_idx == 32'd1) || (w_idx == 32'd2) || w_is_ctrl);
  assign wr_status = wr_fire && (w_idx == 32'd1);
  assign wr_enable = wr_fire && (w_idx == 32'd2);

  // A new edge on irq_in is OR-ed in after the W1C clear so the set wins.
  assign status_clr32 = wr_status ? (s_axi.S_AXI_WDATA & strb_mask(s_axi.S_AXI_WSTRB)) : '0;
  assign status_nxt   = (status_q & ~status_clr32[NUM_IRQ-1:0]) | (irq_in & ~irq_d);
  assign enable_wr32  = apply_strb(irq_ext(enable_q), s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);

  assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                         status_clr32, enable_wr32};

  always_comb begin
    r_data = '0;
    r_err  = 1'b0;
    if (r_idx == 32'd0)      r_data = ID_VALUE;
    else if (r_idx == 32'd1) r_data = irq_ext(status_q);
    else if (r_idx == 32'd2) r_data = irq_ext(enable_q);
    else if (r_idx == 32'd3) r_data = irq_ext(status_q & enable_q);
    else begin
      r_err = 1'b1;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (r_idx == 32'(4 + i)) begin
          r_data = ctrl_q[i];
          r_err  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_CTRL; i++) ctrl_out[32*i +: 32] = ctrl_q[i];
  end

  // Write channel: ready pulse once both halves are present, then hold B.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_err ? RESP_SLVERR : RESP_OKAY;
            w_state   <= W_RESP;
          end else if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end else begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: data is captured on the ARREADY edge and held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_fire) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_data;
            rresp_q   <= r_err ? RESP_SLVERR : RESP_OKAY;
            r_state   <= R_DATA;
          end else begin
            arready_q <= s_axi.S_AXI_ARVALID;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_d             <= '0;
      status_q          <= '0;
      enable_q          <= '0;
      interrupt_request <= 1'b0;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
    end else begin
      irq_d             <= irq_in;
      status_q          <= status_nxt;
      interrupt_request <= |(status_q & enable_q);
      if (wr_enable) enable_q <= enable_wr32[NUM_IRQ-1:0];
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr_fire && (w_idx == 32'(4 + i)))
          ctrl_q[i] <= apply_strb(ctrl_q[i], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank: expected B/R responses are queued at
// issue time and compared when the bank presents them.
module tb_axi_lite_regbank;

  logic         clk;
  logic         rst_n;
  logic [7:0]   irq_in;
  logic [127:0] ctrl_out;
  logic         irq_req;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [1:0]  b_e;
  logic [33:0] r_e;

  axi_lite_regbank_if #(.ADDR_WIDTH(8)) bus ();

  axi_lite_regbank #(
    .ADDR_WIDTH(8), .NUM_CTRL(4), .NUM_IRQ(8), .ID_VALUE(32'h4C4C0001)
  ) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .s_axi            (bus),
    .irq_in           (irq_in),
    .ctrl_out         (ctrl_out),
    .interrupt_request(irq_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
      if (exp_b.size() == 0) check("bresp_unexpected", 32'd1, 32'd0);
      else begin
        b_e = exp_b.pop_front();
        check("bresp", 32'(bus.S_AXI_BRESP), 32'(b_e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      if (exp_r.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
      else begin
        r_e = exp_r.pop_front();
        check("rdata", bus.S_AXI_RDATA, r_e[31:0]);
        check("rresp", 32'(bus.S_AXI_RRESP), 32'(r_e[33:32]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic aw_issue(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] e, input logic [7:0] irq_set);
    bit got = 1'b0;
    exp_b.push_back(e);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin got = 1'b1; break; end
    end
    if (!got) check("aw_timeout", 32'd0, 32'd1);
    irq_in = irq_in | irq_set;
    @(posedge clk);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic ar_issue(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e,
                          input bit expect_rsp);
    bit got = 1'b0;
    if (expect_rsp) exp_r.push_back({e, d});
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_ARREADY) begin got = 1'b1; break; end
    end
    if (!got) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic b_wait();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.S_AXI_BVALID) begin got = 1'b1; break; end
    end
    if (!got) check("b_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic r_wait();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.S_AXI_RVALID) begin got = 1'b1; break; end
    end
    if (!got) check("r_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] e);
    aw_issue(a, d, s, e, 8'h00);
    b_wait();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e);
    ar_issue(a, d, e, 1'b1);
    r_wait();
  endtask

  initial begin
    bit ok;
    rst_n  = 1'b0;
    irq_in = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.S_AXI_AWREADY | bus.S_AXI_WREADY), 32'd0);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID), 32'd0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID), 32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA, 32'd0);
    check("rst_ctrl",    32'(|ctrl_out), 32'd0);
    check("rst_irq",     32'(irq_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Byte-laned CTRL write, visible the cycle after the handshake
    aw_issue(8'h10, 32'hDEADBEEF, 4'b0101, 2'b00, 8'h00);
    @(negedge clk);
    check("ctrl0_strb", ctrl_out[31:0], 32'h00AD00EF);
    b_wait();
    rd(8'h10, 32'h00AD00EF, 2'b00);
    wr(8'h14, 32'h12345678, 4'b1111, 2'b00);
    rd(8'h17, 32'h12345678, 2'b00);
    check("ctrl1_out", ctrl_out[63:32], 32'h12345678);

    rd(8'h00, 32'h4C4C0001, 2'b00);
    rd(8'h20, 32'h00000000, 2'b10);

    wr(8'h08, 32'hFFFFFFFF, 4'b1111, 2'b00);
    rd(8'h08, 32'h000000FF, 2'b00);
    wr(8'h08, 32'h00000001, 4'b0001, 2'b00);
    rd(8'h08, 32'h00000001, 2'b00);

    // Interrupt latency: STATUS one cycle, interrupt_request two cycles
    irq_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("status_lat1", 32'(dut.status_q), 32'h1);
    check("irq_lat1", 32'(irq_req), 32'd0);
    @(negedge clk);
    check("irq_lat2", 32'(irq_req), 32'd1);
    @(posedge clk); #1;
    irq_in[0] = 1'b0;
    rd(8'h04, 32'h00000001, 2'b00);
    rd(8'h0C, 32'h00000001, 2'b00);
    aw_issue(8'h04, 32'h00000001, 4'b1111, 2'b00, 8'h00);
    @(negedge clk);
    check("irq_clr_hold", 32'(irq_req), 32'd1);
    @(negedge clk);
    check("irq_clr_done", 32'(irq_req), 32'd0);
    b_wait();
    rd(8'h04, 32'h00000000, 2'b00);

    // Set/clear collision on bit 3
    irq_in[3] = 1'b1;
    idle(2);
    irq_in[3] = 1'b0;
    idle(2);
    aw_issue(8'h04, 32'h00000008, 4'b1111, 2'b00, 8'h08);
    b_wait();
    irq_in = '0;
    rd(8'h04, 32'h00000008, 2'b00);

    // Error responses leave state alone
    wr(8'h08, 32'h00000009, 4'b0001, 2'b00);
    rd(8'h0C, 32'h00000008, 2'b00);
    wr(8'h0C, 32'hFFFFFFFF, 4'b1111, 2'b10);
    rd(8'h0C, 32'h00000008, 2'b00);
    wr(8'h00, 32'h00000000, 4'b1111, 2'b10);
    wr(8'h20, 32'hFFFFFFFF, 4'b1111, 2'b10);
    check("ctrl0_after_err", ctrl_out[31:0], 32'h00AD00EF);

    // Concurrent read and write under back-pressure
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h00AD00EF});
    bus.S_AXI_AWADDR = 8'h18; bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 8'h10;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY && bus.S_AXI_ARREADY) begin ok = 1'b1; break; end
    end
    if (!ok) check("bp_hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_awready", 32'(bus.S_AXI_AWREADY | bus.S_AXI_WREADY), 32'd0);
      check("bp_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
      check("bp_bvalid",  32'(bus.S_AXI_BVALID), 32'd1);
      check("bp_rvalid",  32'(bus.S_AXI_RVALID), 32'd1);
      check("bp_bresp",   32'(bus.S_AXI_BRESP), 32'd0);
      check("bp_rdata",   bus.S_AXI_RDATA, 32'h00AD00EF);
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    b_wait();
    r_wait();
    rd(8'h18, 32'hA5A5A5A5, 2'b00);

    // Reset while a read response is being held
    bus.S_AXI_RREADY = 1'b0;
    ar_issue(8'h10, 32'h0, 2'b00, 1'b0);
    check("pre_rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    check("async_rst_ctrl",   32'(|ctrl_out), 32'd0);
    check("async_rst_irq",    32'(irq_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.S_AXI_RVALID) ok = 1'b1;
    end
    check("no_rsp_after_rst", 32'(ok), 32'd0);
    @(posedge clk); #1;
    rd(8'h10, 32'h00000000, 2'b00);
    rd(8'h08, 32'h00000000, 2'b00);

    check("exp_b_left", 32'(exp_b.size()), 32'd0);
    check("exp_r_left", 32'(exp_r.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
